// File: rtl/huff_pkg.sv
`timescale 1ns/1ps
// Shared types and width helpers for the parametrised Huffman encoder.
// The per-slot record lives in the top, where the widths are known.
package huff_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_MERGE,
        ST_EMIT
    } state_t;

    function automatic int f_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int f_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int f_wt_w(input int n, input int fw);
        return fw + $clog2(n);
    endfunction

    function automatic int f_len_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int f_code_w(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/huff_min2_find.sv
`timescale 1ns/1ps
// Picks the two lightest active groups; ties go to the lower index.
// Purely combinational.
module huff_min2_find
    import huff_pkg::*;
#(
    parameter int NUM_SYMS = 8,
    parameter int WT_W     = 7,
    localparam int IDX_W   = f_idx_w(NUM_SYMS)
) (
    input  logic [WT_W-1:0]     i_wt [NUM_SYMS],
    input  logic [NUM_SYMS-1:0] i_act,
    output logic [IDX_W-1:0]    o_min1,
    output logic [IDX_W-1:0]    o_min2,
    output logic                o_found2
);

    logic            w_f1;
    logic [WT_W-1:0] w_w1;
    logic [WT_W-1:0] w_w2;

    // Ascending scan with strict compares keeps the lower index on ties.
    always_comb begin
        o_min1   = '0;
        o_min2   = '0;
        o_found2 = 1'b0;
        w_f1     = 1'b0;
        w_w1     = '0;
        w_w2     = '0;
        for (int i = 0; i < NUM_SYMS; i++) begin
            if (i_act[i]) begin
                if (!w_f1 || i_wt[i] < w_w1) begin
                    o_min2   = o_min1;
                    w_w2     = w_w1;
                    o_found2 = w_f1;
                    o_min1   = IDX_W'(i);
                    w_w1     = i_wt[i];
                    w_f1     = 1'b1;
                end else if (!o_found2 || i_wt[i] < w_w2) begin
                    o_min2   = IDX_W'(i);
                    w_w2     = i_wt[i];
                    o_found2 = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/huff_encoder_param.sv
`timescale 1ns/1ps
// Parametrised Huffman encoder: load (sym,freq), merge one pair per
// cycle, then stream (sym,len,code) in load order.
module huff_encoder_param
    import huff_pkg::*;
#(
    parameter int NUM_SYMS = 8,
    parameter int SYM_W    = 8,
    parameter int FREQ_W   = 4,
    localparam int WT_W    = f_wt_w(NUM_SYMS, FREQ_W),
    localparam int CODE_W  = f_code_w(NUM_SYMS),
    localparam int LEN_W   = f_len_w(NUM_SYMS),
    localparam int IDX_W   = f_idx_w(NUM_SYMS),
    localparam int CNT_W   = f_cnt_w(NUM_SYMS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SYM_W-1:0]  in_sym,
    input  logic [FREQ_W-1:0] in_freq,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SYM_W-1:0]  out_sym,
    output logic [LEN_W-1:0]  out_len,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last
);

    typedef struct packed {
        logic [SYM_W-1:0]  sym;
        logic [WT_W-1:0]   wt;
        logic [IDX_W-1:0]  grp;
        logic              act;
        logic              leaf;
        logic [LEN_W-1:0]  len;
        logic [CODE_W-1:0] code;
    } slot_t;

    state_t            r_state;
    state_t            w_state_nxt;
    slot_t             r_slot [NUM_SYMS];
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;

    logic [WT_W-1:0]     w_wt [NUM_SYMS];
    logic [NUM_SYMS-1:0] w_act;
    logic [IDX_W-1:0]    w_min1;
    logic [IDX_W-1:0]    w_min2;
    logic [IDX_W-1:0]    w_lo;
    logic [IDX_W-1:0]    w_hi;
    logic                w_found2;
    logic                w_load_xfer;
    logic                w_load_done;
    logic                w_emit_xfer;
    logic                w_last_word;

    // Flatten slot weights/actives for the minimum finder.
    always_comb begin
        for (int i = 0; i < NUM_SYMS; i++) begin
            w_wt[i]  = r_slot[i].wt;
            w_act[i] = r_slot[i].act;
        end
    end

    huff_min2_find #(
        .NUM_SYMS (NUM_SYMS),
        .WT_W     (WT_W)
    ) u_min2 (
        .i_wt     (w_wt),
        .i_act    (w_act),
        .o_min1   (w_min1),
        .o_min2   (w_min2),
        .o_found2 (w_found2)
    );

    assign w_lo        = (w_min1 < w_min2) ? w_min1 : w_min2;
    assign w_hi        = (w_min1 < w_min2) ? w_min2 : w_min1;
    assign in_ready    = (r_state == ST_LOAD);
    assign out_valid   = (r_state == ST_EMIT);
    assign w_load_xfer = in_valid && in_ready;
    assign w_load_done = w_load_xfer &&
                         (in_last || r_cnt == CNT_W'(NUM_SYMS - 1));
    assign w_emit_xfer = out_valid && out_ready;
    assign w_last_word = (CNT_W'(r_idx) == r_cnt - CNT_W'(1));
    assign out_last    = out_valid && w_last_word;
    assign out_sym     = out_valid ? r_slot[r_idx].sym  : '0;
    assign out_len     = out_valid ? r_slot[r_idx].len  : '0;
    assign out_code    = out_valid ? r_slot[r_idx].code : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_LOAD;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_LOAD:  if (w_load_done) w_state_nxt = ST_MERGE;
            ST_MERGE: if (!w_found2) w_state_nxt = ST_EMIT;
            ST_EMIT:  if (w_emit_xfer && w_last_word) w_state_nxt = ST_LOAD;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    // Slot table: load, one merge per cycle, emit index walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SYMS; i++) r_slot[i] <= '0;
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_load_xfer) begin
                        r_slot[IDX_W'(r_cnt)] <= '{
                            sym:  in_sym,
                            wt:   WT_W'(in_freq),
                            grp:  IDX_W'(r_cnt),
                            act:  (in_freq != '0),
                            leaf: (in_freq != '0),
                            len:  '0,
                            code: '0
                        };
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_MERGE: begin
                    if (w_found2) begin
                        for (int i = 0; i < NUM_SYMS; i++) begin
                            if (r_slot[i].leaf) begin
                                if (r_slot[i].grp == w_min1) begin
                                    r_slot[i].len <= r_slot[i].len + LEN_W'(1);
                                end else if (r_slot[i].grp == w_min2) begin
                                    r_slot[i].code <= r_slot[i].code |
                                        (CODE_W'(1) << r_slot[i].len);
                                    r_slot[i].len <= r_slot[i].len + LEN_W'(1);
                                end
                                if (r_slot[i].grp == w_hi) r_slot[i].grp <= w_lo;
                            end
                        end
                        r_slot[w_lo].wt  <= w_wt[w_min1] + w_wt[w_min2];
                        r_slot[w_hi].act <= 1'b0;
                    end else begin
                        // A lone symbol still needs a one-bit code.
                        for (int i = 0; i < NUM_SYMS; i++) begin
                            if (r_slot[i].leaf && r_slot[i].len == '0)
                                r_slot[i].len <= LEN_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_emit_xfer) begin
                        if (w_last_word) begin
                            r_idx <= '0;
                            r_cnt <= '0;
                            for (int i = 0; i < NUM_SYMS; i++) begin
                                r_slot[i].act  <= 1'b0;
                                r_slot[i].leaf <= 1'b0;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_encoder_param.sv
`timescale 1ns/1ps
// Randomised bench for huff_encoder_param against a group-list
// Huffman reference model.
module tb_huff_encoder_param;

    localparam int N  = 8;
    localparam int SW = 8;
    localparam int FW = 4;
    localparam int LW = 4;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sym;
    logic [FW-1:0] in_freq;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sym;
    logic [LW-1:0] out_len;
    logic [CW-1:0] out_code;
    logic          out_last;

    always #5 clk = ~clk;

    huff_encoder_param #(
        .NUM_SYMS (N),
        .SYM_W    (SW),
        .FREQ_W   (FW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_freq   (in_freq),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_len   (out_len),
        .out_code  (out_code),
        .out_last  (out_last)
    );

    int            n_chk = 0;
    int            n_err = 0;
    logic [SW-1:0] t_sym  [N];
    int            t_freq [N];
    int            m_len  [N];
    int            m_code [N];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: groups named by their lowest member leaf, weights
    // re-summed from leaf frequencies each step.
    task automatic model(input int n);
        int  gid [N];
        int  wt  [N];
        bit  pres[N];
        int  g1, g2, lo, hi, k1, k2;
        for (int j = 0; j < N; j++) begin
            gid[j] = j; m_len[j] = 0; m_code[j] = 0;
        end
        for (int step = 0; step < N; step++) begin
            for (int g = 0; g < N; g++) begin wt[g] = 0; pres[g] = 0; end
            for (int j = 0; j < n; j++)
                if (t_freq[j] != 0) begin
                    wt[gid[j]] += t_freq[j];
                    pres[gid[j]] = 1;
                end
            g1 = -1; g2 = -1; k1 = 1 << 30; k2 = 1 << 30;
            for (int g = 0; g < n; g++)
                if (pres[g] && wt[g] * N + g < k1) begin
                    k1 = wt[g] * N + g; g1 = g;
                end
            for (int g = 0; g < n; g++)
                if (pres[g] && g != g1 && wt[g] * N + g < k2) begin
                    k2 = wt[g] * N + g; g2 = g;
                end
            if (g2 < 0) break;
            for (int j = 0; j < n; j++)
                if (t_freq[j] != 0) begin
                    if (gid[j] == g1) m_len[j]++;
                    else if (gid[j] == g2) begin
                        m_code[j] += (1 << m_len[j]);
                        m_len[j]++;
                    end
                end
            lo = (g1 < g2) ? g1 : g2;
            hi = (g1 < g2) ? g2 : g1;
            for (int j = 0; j < n; j++) if (gid[j] == hi) gid[j] = lo;
        end
        for (int j = 0; j < n; j++)
            if (t_freq[j] != 0 && m_len[j] == 0) m_len[j] = 1;
    endtask

    task automatic do_load(input int n, input bit use_last);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_sym   = t_sym[k];
            in_freq  = FW'(t_freq[k]);
            in_last  = use_last && (k == n - 1);
            chk("in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_word(input string p, input int k, input int n);
        chk({p, "_valid"}, out_valid, 1);
        chk({p, "_sym"},   out_sym,   t_sym[k]);
        chk({p, "_len"},   out_len,   m_len[k]);
        chk({p, "_code"},  out_code,  m_code[k]);
        chk({p, "_last"},  out_last,  (k == n - 1) ? 1 : 0);
    endtask

    task automatic run_table(input int n, input bit use_last,
                             input int stall_at, input int stall_len,
                             input bit rnd);
        int a, cyc, exp_m, st;
        longint kraft;
        model(n);
        a = 0;
        for (int j = 0; j < n; j++) if (t_freq[j] != 0) a++;
        exp_m = ((a > 1) ? a - 1 : 0) + 1;
        do_load(n, use_last);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk("merge_cycles", cyc, exp_m);
        kraft = 0;
        for (int k = 0; k < n; k++) begin
            out_ready = 1'b0;
            st = (k == stall_at) ? stall_len : (rnd ? $urandom_range(0, 2) : 0);
            for (int s = 0; s < st; s++) begin
                @(posedge clk); #1;
                check_word("hold", k, n);
            end
            check_word("word", k, n);
            if (out_len != 0) kraft += longint'(1) << (CW - int'(out_len));
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        if (a >= 2) chk("kraft", 32'(kraft), 32'(1 << CW));
        chk("ready_after", in_ready, 1);
        chk("valid_after", out_valid, 0);
    endtask

    task automatic set3(input int f0, input int f1, input int f2,
                        input byte s0, input byte s1, input byte s2);
        t_sym[0] = s0; t_sym[1] = s1; t_sym[2] = s2;
        t_freq[0] = f0; t_freq[1] = f1; t_freq[2] = f2;
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_sym = '0; in_freq = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sym", out_sym, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_last", out_last, 0);

        set3(1, 2, 3, "A", "B", "C");
        run_table(3, 1, -1, 0, 0);

        set3(5, 1, 1, "a", "b", "c");
        t_sym[3] = "d"; t_freq[3] = 1;
        run_table(4, 1, -1, 0, 0);

        set3(0, 7, 0, "x", "y", "z");
        run_table(3, 1, -1, 0, 0);

        for (int j = 0; j < N; j++) begin t_sym[j] = 8'(j + 16); t_freq[j] = 1; end
        run_table(N, 0, -1, 0, 0);

        for (int j = 0; j < N; j++) begin t_sym[j] = 8'(j + 48); t_freq[j] = 15; end
        run_table(N, 1, 3, 5, 0);

        set3(4, 2, 9, "p", "q", "r");
        do_load(3, 1);
        chk("in_merge", in_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_len", out_len, 0);
        set3(3, 3, 1, "u", "v", "w");
        run_table(3, 1, 1, 2, 0);

        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, N);
            for (int j = 0; j < n; j++) begin
                t_sym[j]  = 8'($urandom);
                t_freq[j] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
            end
            run_table(n, (n < N) ? 1'b1 : 1'($urandom_range(0, 1)), -1, 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
